// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester bundle plus uart handshake seen by the arbiter
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH = 8
);
    localparam int GW = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] lock;
    logic [NUM_REQ*WIDTH-1:0] data_in;
    logic [NUM_REQ-1:0] ack;
    logic uart_busy;
    logic uart_start;
    logic [WIDTH-1:0] uart_data;
    logic [GW-1:0] grant_id;
    logic err;
    modport master (output req, lock, data_in, uart_busy, input ack, uart_start, uart_data, grant_id, err);
    modport slave (input req, lock, data_in, uart_busy, output ack, uart_start, uart_data, grant_id, err);
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter with lock bursts feeding one uart transmitter
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH = 8,
    parameter int BURST_MAX = 16,
    parameter int BUSY_TIMEOUT = 7
) (
    input logic clk,
    input logic reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int GW = $clog2(NUM_REQ);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;
    logic [1:0] state;
    logic [7:0] burst_cnt;
    logic [7:0] cnt;
    logic locked;
    logic [GW-1:0] idx;
    logic [GW-1:0] winner;
    logic [WIDTH-1:0] sel_data;
    // burst_cnt==0 means nothing granted since reset, so the lock override stays off
    always_comb begin
        locked = bus.req[bus.grant_id] && bus.lock[bus.grant_id] && burst_cnt != 8'd0 && burst_cnt < 8'(BURST_MAX);
        winner = bus.grant_id;
        idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = GW'((int'(bus.grant_id) + k) % NUM_REQ);
            if (!locked && bus.req[idx]) winner = idx;
        end
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) if (winner == GW'(i)) sel_data = bus.data_in[i*WIDTH +: WIDTH];
    end
    // grant FSM; ack, uart_start and err are single-cycle pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            bus.ack <= '0;
            bus.uart_start <= 1'b0;
            bus.uart_data <= '0;
            bus.err <= 1'b0;
            bus.grant_id <= GW'(NUM_REQ - 1);
            burst_cnt <= 8'd0;
            cnt <= 8'd0;
        end else begin
            bus.ack <= '0;
            bus.uart_start <= 1'b0;
            bus.err <= 1'b0;
            case (state)
                IDLE: if (bus.req != '0) begin
                    bus.ack <= NUM_REQ'(1) << winner;
                    bus.uart_start <= 1'b1;
                    bus.uart_data <= sel_data;
                    bus.grant_id <= winner;
                    burst_cnt <= locked ? burst_cnt + 8'd1 : 8'd1;
                    state <= START;
                end
                START: begin
                    cnt <= 8'd0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: if (bus.uart_busy) state <= WAIT_DONE;
                else if (cnt == 8'(BUSY_TIMEOUT)) begin
                    bus.err <= 1'b1;
                    state <= IDLE;
                end else cnt <= cnt + 8'd1;
                default: if (!bus.uart_busy) state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized self-checking bench with behavioural arbiter and uart models
module tb_uart_tx_arbiter;
    localparam int NR = 4;
    localparam int W = 8;
    localparam int GW = $clog2(NR);
    localparam int BMAX = 4;
    localparam int TMO = 7;
    localparam int FRAME = 10;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int passed = 0;
    int total = 0;
    int m_last = NR - 1;
    int m_burst = 0;
    int stable_err = 0;
    bit uart_en = 1'b1;
    logic [NR-1:0] r = '0;
    logic [NR-1:0] l = '0;
    logic [W-1:0] dat [NR];
    logic [W-1:0] sent [$];

    uart_tx_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();

    uart_tx_arbiter #(.NUM_REQ(NR), .WIDTH(W), .BURST_MAX(BMAX), .BUSY_TIMEOUT(TMO)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // uart stand-in: busy for FRAME cycles per start, records each byte and checks it stays stable
    initial begin
        logic [W-1:0] cap;
        bus.uart_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (uart_en && bus.uart_start === 1'b1) begin
                cap = bus.uart_data;
                sent.push_back(cap);
                bus.uart_busy = 1'b1;
                repeat (FRAME) @(negedge clk);
                if (bus.uart_data !== cap) stable_err++;
                bus.uart_busy = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end

    // arbitration rule: locked re-grant while under the burst limit, otherwise first requester after the last grant
    function automatic int model_pick(input logic [NR-1:0] rq, input logic [NR-1:0] lk);
        int w = -1;
        if (m_burst > 0 && m_burst < BMAX && rq[GW'(m_last)] && lk[GW'(m_last)]) begin
            m_burst++;
            return m_last;
        end
        for (int k = 1; k <= NR; k++) if (w < 0 && rq[GW'((m_last + k) % NR)]) w = (m_last + k) % NR;
        m_last = w;
        m_burst = 1;
        return w;
    endfunction

    task automatic apply();
        bus.req = r;
        bus.lock = l;
        for (int i = 0; i < NR; i++) bus.data_in[i*W +: W] = dat[i];
    endtask

    task automatic wait_ack(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            ok = bus.ack !== '0;
        end
    endtask

    task automatic settle();
        for (int i = 0; i < 4 * FRAME && bus.uart_busy === 1'b1; i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        settle();
        r = '0;
        l = '0;
        apply();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_last = NR - 1;
        m_burst = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NR; i++) dat[i] = W'(8'h10 + i);
        r = '0;
        l = '0;
        apply();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (bus.ack !== '0 || bus.uart_start !== 1'b0 || bus.uart_data !== '0 || bus.err !== 1'b0 || bus.grant_id !== GW'(NR - 1))
            $display("FAIL reset_values: ack=%b start=%b data=%h err=%b gid=%0d, required 0 0 00 0 %0d", bus.ack, bus.uart_start, bus.uart_data, bus.err, bus.grant_id, NR - 1);
        else passed++;
        reset = 1'b0;
        m_last = NR - 1;
        m_burst = 0;
        repeat (5) @(negedge clk);
        total++;
        if (bus.ack !== '0 || bus.uart_start !== 1'b0 || bus.grant_id !== GW'(NR - 1))
            $display("FAIL idle_no_req: ack=%b start=%b gid=%0d, required 0 0 %0d", bus.ack, bus.uart_start, bus.grant_id, NR - 1);
        else passed++;
    endtask

    task automatic test_single();
        bit ok;
        sent.delete();
        r = 4'b0100;
        dat[2] = 8'h41;
        apply();
        wait_ack(1, ok);
        total++;
        if (!ok || bus.ack !== 4'b0100 || bus.uart_start !== 1'b1 || bus.uart_data !== 8'h41 || bus.grant_id !== 2'd2)
            $display("FAIL single_grant: ack=%b start=%b data=%h gid=%0d, required 0100 1 41 2", bus.ack, bus.uart_start, bus.uart_data, bus.grant_id);
        else passed++;
        void'(model_pick(r, l));
        r = '0;
        apply();
        @(negedge clk);
        total++;
        if (bus.ack !== '0 || bus.uart_start !== 1'b0)
            $display("FAIL single_pulse: ack=%b start=%b one cycle later, required 0000 0", bus.ack, bus.uart_start);
        else passed++;
        settle();
        total++;
        if (sent.size() != 1 || sent[0] !== 8'h41)
            $display("FAIL single_uart: %0d bytes sent, first=%h, required 1 byte 41", sent.size(), sent.size() > 0 ? sent[0] : 8'h00);
        else passed++;
    endtask

    task automatic test_fairness();
        bit ok;
        do_reset();
        r = 4'b1111;
        apply();
        for (int g = 0; g < 5; g++) begin
            wait_ack(4 * FRAME, ok);
            total++;
            if (!ok || bus.ack !== NR'(1) << (g % NR) || bus.grant_id !== GW'(g % NR) || bus.uart_data !== dat[GW'(g % NR)])
                $display("FAIL fair_grant%0d: ack=%b gid=%0d data=%h, required gid=%0d data=%h", g, bus.ack, bus.grant_id, bus.uart_data, g % NR, dat[GW'(g % NR)]);
            else passed++;
            void'(model_pick(r, l));
            dat[GW'(g % NR)] = W'($urandom);
            apply();
            @(negedge clk);
        end
        r = '0;
        apply();
    endtask

    task automatic test_lock();
        bit ok;
        int order [6] = '{0, 0, 0, 0, 1, 0};
        do_reset();
        r = 4'b0011;
        l = 4'b0001;
        apply();
        for (int g = 0; g < 6; g++) begin
            wait_ack(4 * FRAME, ok);
            total++;
            if (!ok || bus.ack !== NR'(1) << order[g] || bus.grant_id !== GW'(order[g]))
                $display("FAIL lock_grant%0d: ack=%b gid=%0d, required gid=%0d", g, bus.ack, bus.grant_id, order[g]);
            else passed++;
            void'(model_pick(r, l));
            if (order[g] == 1) r[1] = 1'b0;
            apply();
            @(negedge clk);
        end
        r = '0;
        l = '0;
        apply();
    endtask

    task automatic test_timeout();
        bit ok;
        bit early = 1'b0;
        settle();
        uart_en = 1'b0;
        r = 4'b0001;
        apply();
        wait_ack(2, ok);
        total++;
        if (!ok || bus.ack !== 4'b0001)
            $display("FAIL timeout_ack: ack=%b, required 0001", bus.ack);
        else passed++;
        r = 4'b0010;
        apply();
        for (int i = 0; i < TMO + 1; i++) begin
            @(negedge clk);
            if (bus.err !== 1'b0) early = 1'b1;
        end
        total++;
        if (early) $display("FAIL timeout_early: err=1 within the %0d busy-wait cycles, required 0", TMO + 1);
        else passed++;
        @(negedge clk);
        total++;
        if (bus.err !== 1'b1 || bus.ack !== '0)
            $display("FAIL timeout_err: err=%b ack=%b, required err=1 ack=0000", bus.err, bus.ack);
        else passed++;
        @(negedge clk);
        total++;
        if (bus.err !== 1'b0 || bus.ack !== 4'b0010 || bus.grant_id !== 2'd1)
            $display("FAIL timeout_next: err=%b ack=%b gid=%0d, required 0 0010 1", bus.err, bus.ack, bus.grant_id);
        else passed++;
        r = '0;
        apply();
        repeat (TMO + 6) @(negedge clk);
        uart_en = 1'b1;
    endtask

    task automatic test_reset_midframe();
        bit ok;
        bit spurious = 1'b0;
        do_reset();
        r = 4'b0001;
        apply();
        wait_ack(2, ok);
        total++;
        if (!ok || bus.ack !== 4'b0001)
            $display("FAIL midframe_first: ack=%b, required 0001", bus.ack);
        else passed++;
        r = '0;
        apply();
        repeat (4) @(negedge clk);
        r = 4'b0010;
        dat[1] = W'($urandom);
        apply();
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (bus.ack !== '0 || bus.uart_start !== 1'b0 || bus.uart_data !== '0 || bus.err !== 1'b0 || bus.grant_id !== GW'(NR - 1))
            $display("FAIL midframe_reset: ack=%b start=%b data=%h err=%b gid=%0d, required 0 0 00 0 %0d", bus.ack, bus.uart_start, bus.uart_data, bus.err, bus.grant_id, NR - 1);
        else passed++;
        for (int i = 0; i < 4 * FRAME && bus.uart_busy === 1'b1; i++) begin
            @(negedge clk);
            if (bus.ack !== '0 || bus.uart_start !== 1'b0) spurious = 1'b1;
        end
        reset = 1'b0;
        m_last = NR - 1;
        m_burst = 0;
        total++;
        if (spurious) $display("FAIL midframe_hold: ack or start seen while reset held, required none");
        else passed++;
        wait_ack(2, ok);
        total++;
        if (!ok || bus.ack !== 4'b0010 || bus.grant_id !== 2'd1 || bus.uart_data !== dat[1])
            $display("FAIL midframe_after: ack=%b gid=%0d data=%h, required 0010 1 %h", bus.ack, bus.grant_id, bus.uart_data, dat[1]);
        else passed++;
        r = '0;
        apply();
    endtask

    task automatic test_random();
        bit ok;
        int w;
        int bad = 0;
        logic [W-1:0] exp_q [$];
        do_reset();
        sent.delete();
        stable_err = 0;
        r = NR'($urandom_range(1, 2**NR - 1));
        for (int i = 0; i < NR; i++) dat[i] = W'($urandom);
        apply();
        for (int n = 0; n < 50; n++) begin
            wait_ack(4 * FRAME, ok);
            w = model_pick(r, l);
            exp_q.push_back(dat[GW'(w)]);
            total++;
            if (!ok || bus.ack !== NR'(1) << w || bus.grant_id !== GW'(w) || bus.uart_start !== 1'b1 || bus.uart_data !== dat[GW'(w)])
                $display("FAIL rand_grant%0d: req=%b lock=%b ack=%b gid=%0d data=%h, required gid=%0d data=%h", n, r, l, bus.ack, bus.grant_id, bus.uart_data, w, dat[GW'(w)]);
            else passed++;
            @(negedge clk);
            if (bus.ack !== '0 || bus.uart_start !== 1'b0) bad++;
            r = NR'($urandom_range(1, 2**NR - 1));
            l = $urandom_range(0, 3) == 0 ? '0 : NR'($urandom);
            for (int i = 0; i < NR; i++) dat[i] = W'($urandom);
            apply();
        end
        r = '0;
        l = '0;
        apply();
        settle();
        total++;
        if (bad != 0) $display("FAIL rand_pulse: %0d grants left ack/start high a second cycle, required 0", bad);
        else passed++;
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < sent.size(); i++) if (sent[i] !== exp_q[i]) bad++;
        total++;
        if (sent.size() != exp_q.size() || bad != 0 || stable_err != 0)
            $display("FAIL rand_uart: %0d bytes sent with %0d wrong and %0d unstable, required %0d bytes 0 wrong 0 unstable", sent.size(), bad, stable_err, exp_q.size());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_lock();
        test_timeout();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
